// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length byte, N little-endian 32-bit words and an XOR
// checksum over a byte stream, writes the words into instruction memory, then releases the core.
module imem_boot_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_run,
  output logic              load_err
);

  // state | meaning
  // LEN   | waiting for the word-count byte
  // BYTE  | assembling the current word, 4 bytes little-endian
  // WRITE | one-cycle write strobe of the assembled word
  // CSUM  | waiting for the XOR checksum byte
  // RUN   | load complete, core released (terminal)
  // ERR   | bad length or checksum (terminal)
  typedef enum logic [2:0] {
    S_LEN, S_BYTE, S_WRITE, S_CSUM, S_RUN, S_ERR
  } state_t;

  localparam int LEN_W = ADDR_W + 1;

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [1:0]          bcnt_q;
  logic [23:0]         shift_q;
  logic [7:0]          xor_q;
  logic                rx_ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                core_run_q;
  logic                load_err_q;

  logic                accept;
  logic [LEN_W-1:0]    idx_d;

  assign accept = rx_valid & rx_ready_q;
  assign idx_d  = idx_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= S_LEN;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      xor_q      <= '0;
      rx_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      core_run_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            if (rx_data == 8'd0) begin
              state_q    <= S_RUN;
              rx_ready_q <= 1'b0;
              core_run_q <= 1'b1;
            end else if (int'(rx_data) > DEPTH) begin
              state_q    <= S_ERR;
              rx_ready_q <= 1'b0;
              load_err_q <= 1'b1;
            end else begin
              len_q   <= LEN_W'(rx_data);
              state_q <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (accept) begin
            xor_q  <= xor_q ^ rx_data;
            bcnt_q <= bcnt_q + 2'd1;
            case (bcnt_q)
              2'd0:    shift_q[7:0]   <= rx_data;
              2'd1:    shift_q[15:8]  <= rx_data;
              2'd2:    shift_q[23:16] <= rx_data;
              default: begin
                wr_data_q  <= {rx_data, shift_q};
                wr_addr_q  <= idx_q[ADDR_W-1:0];
                wr_en_q    <= 1'b1;
                rx_ready_q <= 1'b0;
                state_q    <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          wr_en_q    <= 1'b0;
          rx_ready_q <= 1'b1;
          idx_q      <= idx_d;
          state_q    <= (idx_d == len_q) ? S_CSUM : S_BYTE;
        end
        S_CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (rx_data == xor_q) begin
              state_q    <= S_RUN;
              core_run_q <= 1'b1;
            end else begin
              state_q    <= S_ERR;
              load_err_q <= 1'b1;
            end
          end
        end
        S_RUN, S_ERR: state_q <= state_q;
        default: begin
          state_q    <= S_LEN;
          rx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign core_run = core_run_q;
  assign load_err = load_err_q;

endmodule
